marin_reset_ctrl: RTL
=====================

// Module: marin_reset_ctrl
//
// PURPOSE
//   Board-level reset sequencer that drives the marin SoC reset input.
//   - Merges four reset sources: power-on, PLL lock, push-button and software request.
//   - Synchronises and debounces the asynchronous inputs.
//   - Enforces a minimum reset width.
//   - Produces one SoC reset: asserted asynchronously, deasserted synchronously.
//   - Records the cause of the most recent reset.
//
// PARAMETERS
//   SYNC_STAGES      2        flip-flop stages on pll_locked_i and btn_i (>=2)
//   DEBOUNCE_CYCLES  1000000  cycles btn_i must be stable before accepted (10 ms @ 100 MHz)
//   HOLD_CYCLES      128      cycles rst_o stays high after lock is seen (>=1)
//   CNT_W            20       width of debounce/hold counters; must hold max(DEBOUNCE,HOLD)-1
//
// PORTS
//   clk_i          in   1  system clock (100 MHz)
//   rst_n_i        in   1  asynchronous active-low power-on reset
//   pll_locked_i   in   1  PLL lock, asynchronous
//   btn_i          in   1  reset push-button, active-high, asynchronous, bouncy
//   sw_rst_i       in   1  one-cycle software reset request, clk_i domain
//   rst_o          out  1  active-high SoC reset (feeds marin rst_i)
//   rst_cause_o    out  2  cause of last reset: 00 POR, 01 LOCK_LOSS, 10 BUTTON, 11 SW
//
// BEHAVIOUR
//   Reset
//   - rst_n_i low immediately forces the following, regardless of clock:
//     rst_o=1, rst_cause_o=00, state=S_WAIT_LOCK, synchronisers=0,
//     btn_deb=0, all counters=0.
//   Synchronisers
//   - lock_s is pll_locked_i delayed by SYNC_STAGES edges.
//   - btn_s is btn_i delayed by SYNC_STAGES edges.
//   Debounce
//   - When btn_s != btn_deb, the counter increments each cycle.
//   - When btn_s == btn_deb, the counter clears.
//   - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still differing,
//     btn_deb <= btn_s and the counter clears.
//   - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
//   FSM (state and rst_o are registered; rst_o = 1 in every state except S_RUN)
//   - S_WAIT_LOCK: enters S_HOLD with hold_cnt=0 when lock_s=1 and btn_deb=0.
//   - S_HOLD:
//     - If lock_s=0: go to S_WAIT_LOCK, cause=01.
//     - Else if btn_deb=1: hold_cnt <= 0 and stay in S_HOLD.
//     - Else if hold_cnt==HOLD_CYCLES-1: go to S_RUN; rst_o <= 0 on the same edge.
//     - Else: hold_cnt++.
//   - S_RUN: exits to S_WAIT_LOCK with rst_o <= 1 on the same edge.
//     - Exit sources: lock_s=0 (cause 01), btn_deb rises (cause 10), sw_rst_i=1 (cause 11).
//     - Simultaneous sources: priority LOCK > BUTTON > SW; only the winner is recorded.
//   - sw_rst_i is ignored outside S_RUN.
//   - rst_cause_o updates only on an exit from S_RUN or S_HOLD and holds otherwise.
//   Latency
//   - First edge sampling pll_locked_i=1 is edge k, button idle.
//   - rst_o falls after edge k+SYNC_STAGES+HOLD_CYCLES.
//   - Reset assertion from a source (sync/debounce done) is a single edge.
//   Lock loss during debounce
//   - The debounce counter keeps running independently of the FSM.
//   - A held button keeps the FSM in S_HOLD; it does not re-trigger on release.
//   Stuck lock
//   - If lock never arrives, rst_o stays high indefinitely.
//
// TESTING
//   1. POR: rst_n_i=0 then 1, pll_locked_i=1 from start, SYNC=2, HOLD=8
//      -> rst_o falls exactly 10 edges after the first lock sample; cause=00.
//   2. Lock loss: in S_RUN drop pll_locked_i for 1 cycle
//      -> rst_o=1 after 3 edges; cause=01; rst_o falls again 10 edges after lock returns.
//   3. Bounce: DEBOUNCE=16; pulse btn_i 10 cycles x5 with 3-cycle gaps
//      -> rst_o stays 0; then hold 20 cycles -> rst_o=1, cause=10.
//      -> After release, rst_o falls HOLD_CYCLES+1 edges after btn_deb clears.
//   4. Software: in S_RUN pulse sw_rst_i 1 cycle -> rst_o=1 on next edge, cause=11;
//      sw_rst_i pulsed during S_HOLD -> no effect.
//   5. Simultaneous: same edge lock_s falls, btn_deb rises and sw_rst_i=1 -> cause=01.
//   6. Async reset mid-S_HOLD: rst_n_i low between edges -> rst_o=1 and cause=00
//      immediately; full sequence restarts.

Source files
------------

// File: rtl/marin_reset_ctrl.sv
// Board-level reset sequencer for the marin SoC: merges POR, PLL lock, push-button
// and software reset sources into one reset that asserts async and releases sync.
module marin_reset_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 128,
  parameter int CNT_W           = 20
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       btn_i,
  input  logic       sw_rst_i,
  output logic       rst_o,
  output logic [1:0] rst_cause_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync_reg;
  logic [SYNC_STAGES-1:0] btn_sync_reg;
  logic                   lock_s;
  logic                   btn_s;

  logic [CNT_W-1:0]       deb_cnt_reg;
  logic                   btn_deb_reg;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       hold_cnt_reg, hold_cnt_next;
  logic [1:0]             cause_reg, cause_next;
  logic                   rst_reg, rst_next;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_sync_reg <= '0;
      btn_sync_reg  <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync_reg  <= {btn_sync_reg[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign lock_s = lock_sync_reg[SYNC_STAGES-1];
  assign btn_s  = btn_sync_reg[SYNC_STAGES-1];

  // Debounce runs independently of the FSM so a press is tracked even during lock loss.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      deb_cnt_reg <= '0;
      btn_deb_reg <= 1'b0;
    end else if (btn_s == btn_deb_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == DEB_LAST) begin
      btn_deb_reg <= btn_s;
      deb_cnt_reg <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= S_WAIT_LOCK;
      hold_cnt_reg <= '0;
      cause_reg    <= CAUSE_POR;
      rst_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      cause_reg    <= cause_next;
      rst_reg      <= rst_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    cause_next    = cause_reg;
    case (state_reg)
      S_WAIT_LOCK: begin
        if (lock_s && !btn_deb_reg) begin
          state_next    = S_HOLD;
          hold_cnt_next = '0;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_LOCK;
        end else if (btn_deb_reg) begin
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = S_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        // Priority order decides which single cause is recorded.
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_LOCK;
        end else if (btn_deb_reg) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_BTN;
        end else if (sw_rst_i) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_SW;
        end
      end
      default: state_next = S_WAIT_LOCK;
    endcase
    rst_next = (state_next != S_RUN);
  end

  assign rst_o       = rst_reg;
  assign rst_cause_o = cause_reg;

endmodule
